// File: rtl/spi_interface_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_interface_master
//  Purpose  : SPI mode-0 master running one fixed-format read per start:
//             shifts out a TX_BITS header (TX_WORD, MSB first), then shifts
//             in an RX_BITS response (MSB first). spi_clk = clk / CLK_DIV.
//  Ports    : clk, rst_n        - system clock / async active-low reset
//             send_en           - start request (ignored while busy)
//             spi_clk, spi_cs_n - serial clock (idles low), chip select
//             mosi, miso        - serial data out / in
//             rx_data, rx_valid - received byte and its one-clock strobe
//             busy              - transaction in progress
//  Options  : `define SPI_CS_GUARD_EN adds a GUARD_CYCLES chip-select-high
//             window after each transaction during which busy stays high.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_interface_master #(
  parameter int                 CLK_DIV      = 4,
  parameter int                 TX_BITS      = 24,
  parameter int                 RX_BITS      = 8,
  parameter logic [TX_BITS-1:0] TX_WORD      = 24'h03_0000,
  parameter int                 GUARD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               send_en,
  output logic               spi_clk,
  output logic               spi_cs_n,
  output logic               mosi,
  input  logic               miso,
  output logic [RX_BITS-1:0] rx_data,
  output logic               rx_valid,
  output logic               busy
);

  localparam int PH_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2((TX_BITS > RX_BITS) ? TX_BITS : RX_BITS) + 1;

  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV / 2);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(TX_BITS - 1);
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(RX_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TX    = 3'd1,
    S_RX    = 3'd2,
    S_END   = 3'd3,
    S_GUARD = 3'd4
  } state_t;

  state_t             state_q,    state_d;
  logic [PH_W-1:0]    ph_q,       ph_d;
  logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [TX_BITS-1:0] tx_sh_q,    tx_sh_d;
  logic [RX_BITS-1:0] rx_sh_q,    rx_sh_d;
  logic [RX_BITS-1:0] rx_data_q,  rx_data_d;
  logic               spi_clk_q,  spi_clk_d;
  logic               spi_cs_n_q, spi_cs_n_d;
  logic               mosi_q,     mosi_d;
  logic               rx_valid_q, rx_valid_d;
  logic               busy_q,     busy_d;

  logic [PH_W-1:0]    ph_nxt;
  logic [TX_BITS-1:0] tx_shifted;

`ifdef SPI_CS_GUARD_EN
  localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
  logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
`endif

  // Phase counter advances every clock while shifting; wraps at the bit boundary.
  assign ph_nxt     = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
  assign tx_shifted = tx_sh_q << 1;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    spi_clk_d  = spi_clk_q;
    spi_cs_n_d = spi_cs_n_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
`ifdef SPI_CS_GUARD_EN
    guard_cnt_d = guard_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (send_en) begin
          state_d    = S_TX;
          spi_cs_n_d = 1'b0;
          busy_d     = 1'b1;
          mosi_d     = TX_WORD[TX_BITS-1];
          tx_sh_d    = TX_WORD;
          rx_sh_d    = '0;
          ph_d       = '0;
          bit_cnt_d  = '0;
          spi_clk_d  = 1'b0;
        end
      end

      S_TX: begin
        ph_d      = ph_nxt;
        spi_clk_d = (ph_nxt >= PH_HALF);
        // Bit boundary coincides with the spi_clk falling edge.
        if (ph_q == PH_LAST) begin
          if (bit_cnt_q == TX_LAST) begin
            state_d   = S_RX;
            mosi_d    = 1'b0;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_sh_d   = tx_shifted;
            mosi_d    = tx_shifted[TX_BITS-1];
          end
        end
      end

      S_RX: begin
        ph_d      = ph_nxt;
        spi_clk_d = (ph_nxt >= PH_HALF);
        // Capture miso at the edge that raises spi_clk.
        if (ph_nxt == PH_HALF)
          rx_sh_d = (rx_sh_q << 1) | RX_BITS'(miso);
        // END occupies the final phase of the last bit, so the closing
        // edge of END is also the last spi_clk falling edge.
        if ((ph_nxt == PH_LAST) && (bit_cnt_q == RX_LAST))
          state_d = S_END;
        else if (ph_q == PH_LAST)
          bit_cnt_d = bit_cnt_q + 1'b1;
      end

      S_END: begin
        spi_cs_n_d = 1'b1;
        spi_clk_d  = 1'b0;
        ph_d       = '0;
        mosi_d     = 1'b0;
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
`ifdef SPI_CS_GUARD_EN
        state_d     = S_GUARD;
        guard_cnt_d = '0;
`else
        state_d    = S_IDLE;
        busy_d     = 1'b0;
`endif
      end

`ifdef SPI_CS_GUARD_EN
      S_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      bit_cnt_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      spi_clk_q  <= 1'b0;
      spi_cs_n_q <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SPI_CS_GUARD_EN
      guard_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      spi_clk_q  <= spi_clk_d;
      spi_cs_n_q <= spi_cs_n_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
`ifdef SPI_CS_GUARD_EN
      guard_cnt_q <= guard_cnt_d;
`endif
    end
  end

  assign spi_clk  = spi_clk_q;
  assign spi_cs_n = spi_cs_n_q;
  assign mosi     = mosi_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_interface_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_interface_master
//  Purpose  : Self-checking bench for spi_interface_master. A slave model
//             returns a chosen byte; expected bytes go into a scoreboard
//             queue and a negedge monitor checks every completed read.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_interface_master;

  localparam int                 CLK_DIV      = 4;
  localparam int                 TX_BITS      = 24;
  localparam int                 RX_BITS      = 8;
  localparam logic [TX_BITS-1:0] TX_WORD      = 24'h03_0000;
  localparam int                 GUARD_CYCLES = 4;
  localparam int                 TXN_CLKS     = (TX_BITS + RX_BITS) * CLK_DIV;
`ifdef SPI_CS_GUARD_EN
  localparam int                 GAP_CLKS     = 1 + GUARD_CYCLES;
`else
  localparam int                 GAP_CLKS     = 1;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               send_en = 1'b0;
  logic               miso = 1'bz;
  logic               spi_clk, spi_cs_n, mosi, rx_valid, busy;
  logic [RX_BITS-1:0] rx_data;

  spi_interface_master #(
    .CLK_DIV      (CLK_DIV),
    .TX_BITS      (TX_BITS),
    .RX_BITS      (RX_BITS),
    .TX_WORD      (TX_WORD),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .send_en  (send_en),
    .spi_clk  (spi_clk),
    .spi_cs_n (spi_cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int rx_count = 0;
  int exp_count = 0;

  logic [RX_BITS-1:0] slave_q[$];  // bytes the slave returns, per transaction
  logic [RX_BITS-1:0] exp_q[$];    // bytes the scoreboard expects on rx_valid

  bit b2b_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic               prev_cs = 1'b1, prev_sck = 1'b0, prev_rxv = 1'b0;
  int                 cs_len = 0, rises = 0, gap = 0;
  bit                 gap_valid = 1'b0, b2b_started = 1'b0, rx_mosi_bad = 1'b0;
  logic [TX_BITS-1:0] mosi_word = '0;
  logic [RX_BITS-1:0] cur_byte = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs = 1'b1; prev_sck = 1'b0; prev_rxv = 1'b0;
      cs_len = 0; rises = 0; gap_valid = 1'b0; b2b_started = 1'b0;
      miso = 1'bz;
    end else begin
      if (prev_cs && !spi_cs_n) begin
        if (b2b_mode && b2b_started && gap_valid)
          check("cs_high_gap", gap, GAP_CLKS);
        b2b_started = b2b_mode;
        check("busy_at_start", {31'd0, busy}, 32'd1);
        cs_len = 0; rises = 0; mosi_word = '0; rx_mosi_bad = 1'b0;
        cur_byte = (slave_q.size() != 0) ? slave_q.pop_front() : '0;
        miso = 1'bz;
      end
      if (!spi_cs_n) cs_len++;
      if (!prev_sck && spi_clk) begin
        rises++;
        if (rises <= TX_BITS) mosi_word = {mosi_word[TX_BITS-2:0], mosi};
        else if (mosi !== 1'b0) rx_mosi_bad = 1'b1;
      end
      // Slave presents the next response bit on each spi_clk fall.
      if (prev_sck && !spi_clk) begin
        if (rises >= TX_BITS && rises < TX_BITS + RX_BITS) begin
          int idx;
          idx = RX_BITS - 1 - (rises - TX_BITS);
          miso = cur_byte[idx];
        end else begin
          miso = 1'bz;
        end
      end
      if (rx_valid) begin
        rx_count++;
        check("rx_valid_single_pulse", {31'd0, prev_rxv}, 32'd0);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rx_valid: got rx_data %0h expected no transaction", rx_data);
        end else begin
          logic [RX_BITS-1:0] e;
          e = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e});
          check("cs_low_clocks", cs_len, TXN_CLKS);
          check("spi_clk_rises", rises, TX_BITS + RX_BITS);
          check("mosi_header", {8'd0, mosi_word}, {8'd0, TX_WORD});
          check("mosi_zero_in_rx", {31'd0, rx_mosi_bad}, 32'd0);
          check("cs_high_with_valid", {31'd0, spi_cs_n}, 32'd1);
        end
      end
      if (!prev_cs && spi_cs_n) begin gap = 1; gap_valid = 1'b1; end
      else if (spi_cs_n) gap++;
      prev_cs = spi_cs_n; prev_sck = spi_clk; prev_rxv = rx_valid;
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic wait_idle(input string name, input int max_clks);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (busy && n < max_clks);
    if (busy) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got busy=1 after %0d clocks expected 0", name, n);
    end
  endtask

  task automatic start_read(input logic [RX_BITS-1:0] b, input bit expect_done);
    @(negedge clk); #2;
    slave_q.push_back(b);
    if (expect_done) begin exp_q.push_back(b); exp_count++; end
    send_en = 1'b1;
    @(negedge clk); #2;
    send_en = 1'b0;
    check("cs_latency", {31'd0, spi_cs_n}, 32'd0);
  endtask

  task automatic do_read(input logic [RX_BITS-1:0] b);
    start_read(b, 1'b1);
    wait_idle("read", TXN_CLKS + 40);
  endtask

  initial begin
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    check("reset_cs_n",    {31'd0, spi_cs_n}, 32'd1);
    check("reset_spi_clk", {31'd0, spi_clk},  32'd0);
    check("reset_mosi",    {31'd0, mosi},     32'd0);
    check("reset_busy",    {31'd0, busy},     32'd0);
    check("reset_rx_data", {24'd0, rx_data},  32'd0);
    check("reset_rx_valid",{31'd0, rx_valid}, 32'd0);

    // Basic and pattern reads.
    do_read(8'hFF);
    do_read(8'hA5);
    do_read(8'h00);

    // Busy reject: second pulse 50 clocks in must not start another read.
    start_read(8'h3C, 1'b1);
    repeat (49) @(negedge clk);
    #2 send_en = 1'b1;
    @(negedge clk); #2 send_en = 1'b0;
    wait_idle("busy_reject", TXN_CLKS + 40);
    repeat (TXN_CLKS + 20) @(negedge clk);
    #1 check("busy_reject_idle", {31'd0, spi_cs_n}, 32'd1);

    // Mid-transfer reset at clock 60: no rx_valid, outputs back to reset.
    start_read(8'h5A, 1'b0);
    repeat (59) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs_n",    {31'd0, spi_cs_n}, 32'd1);
    check("midrst_spi_clk", {31'd0, spi_clk},  32'd0);
    check("midrst_mosi",    {31'd0, mosi},     32'd0);
    check("midrst_busy",    {31'd0, busy},     32'd0);
    check("midrst_rx_data", {24'd0, rx_data},  32'd0);
    slave_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    do_read(8'hC3);

    // Randomized reads with random idle spacing.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_read(8'($urandom));
    end

    // Back-to-back: send_en held high for three transactions.
    begin
      int target, n;
      @(negedge clk); #2;
      b2b_mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
        logic [RX_BITS-1:0] b;
        b = 8'($urandom);
        slave_q.push_back(b); exp_q.push_back(b); exp_count++;
      end
      target = rx_count + 3;
      send_en = 1'b1;
      n = 0;
      do begin
        @(negedge clk); #1;
        n++;
      end while (rx_count < target && n < 3 * (TXN_CLKS + 20));
      send_en = 1'b0;
      check("b2b_done", rx_count, target);
      wait_idle("b2b", 40);
      b2b_mode = 1'b0;
    end

    repeat (TXN_CLKS + 20) @(negedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("rx_valid_total", rx_count, exp_count);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
